// File: rtl/freq_div_pkg.sv
// Shared definitions for the programmable clock divider: FSM encoding and
// the smallest divide ratio the hardware supports.
package freq_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/freq_div_cnt.sv
// Period counter for freq_divide_prog: counts 0..term while running, and
// reloads its terminal value (ratio - 1) on request.
module freq_div_cnt #(
    parameter int unsigned      CNT_W    = 16,
    parameter logic [CNT_W-1:0] RST_TERM = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_term_i,
    output logic [CNT_W-1:0] cnt_d_o,
    output logic [CNT_W-1:0] term_d_o,
    output logic             wrap_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] term_q, term_d;

    assign wrap_o = run_i && (cnt_q == term_q);

    always_comb begin
        cnt_d  = '0;
        term_d = term_q;
        if (run_i && !wrap_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (load_i) begin
            term_d = load_term_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            term_q <= RST_TERM;
        end else begin
            cnt_q  <= cnt_d;
            term_q <= term_d;
        end
    end

    assign cnt_d_o  = cnt_d;
    assign term_d_o = term_d;

endmodule

// File: rtl/freq_divide_prog.sv
// Programmable clock divider with glitch-free ratio changes at period wrap.
// Optional FREQ_DIV_TICK_EN adds a one-cycle 'tick' output on every period start.
module freq_divide_prog
    import freq_div_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             pending,
    output logic             out_clk
`ifdef FREQ_DIV_TICK_EN
    ,
    output logic             tick
`endif
);

    localparam logic [CNT_W-1:0] MIN_N    = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] DEF_N    = (DEFAULT_DIV < MIN_DIV) ? MIN_N : CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DEF_TERM = DEF_N - CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             out_clk_q, out_clk_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_term;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] term_d;
    logic             wrap;
    logic [CNT_W-1:0] cap;

    assign cap = (div_val < MIN_N) ? MIN_N : div_val;

    freq_div_cnt #(
        .CNT_W    (CNT_W),
        .RST_TERM (DEF_TERM)
    ) u_cnt (
        .clk_i       (clk),
        .rst_ni      (rst),
        .run_i       (state_q == RUN),
        .load_i      (cnt_load),
        .load_term_i (cnt_load_term),
        .cnt_d_o     (cnt_d),
        .term_d_o    (term_d),
        .wrap_o      (wrap)
    );

    // IDLE applies ratios immediately; RUN defers them to the wrap edge, where a
    // coincident load only refills the shadow for the following period.
    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        pending_d     = pending_q;
        cnt_load      = 1'b0;
        cnt_load_term = shadow_q - CNT_W'(1);
        unique case (state_q)
            IDLE: begin
                pending_d = 1'b0;
                if (div_load) begin
                    shadow_d      = cap;
                    cnt_load      = 1'b1;
                    cnt_load_term = cap - CNT_W'(1);
                end else if (pending_q) begin
                    cnt_load = 1'b1;
                end
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (wrap) begin
                    cnt_load  = pending_q;
                    pending_d = 1'b0;
                    if (!en) begin
                        state_d = IDLE;
                    end
                end
                if (div_load) begin
                    shadow_d  = cap;
                    pending_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // High while next count <= (N-1)/2, i.e. cnt < ceil(N/2).
    always_comb begin
        out_clk_d = (state_d == RUN) && (cnt_d <= (term_d >> 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shadow_q  <= DEF_N;
            pending_q <= 1'b0;
            out_clk_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            out_clk_q <= out_clk_d;
        end
    end

    assign pending = pending_q;
    assign out_clk = out_clk_q;

`ifdef FREQ_DIV_TICK_EN
    logic tick_q, tick_d;

    always_comb begin
        tick_d = (state_d == RUN) && ((state_q == IDLE) || wrap);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
`endif

endmodule

// File: tb/tb_freq_divide_prog.sv
// Scoreboard bench for freq_divide_prog: directed scenarios plus random
// stimulus against a period/phase reference model.
module tb_freq_divide_prog;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned DEF   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             div_load = 1'b0;
    logic [CNT_W-1:0] div_val = '0;
    logic             pending;
    logic             out_clk;
`ifdef FREQ_DIV_TICK_EN
    logic             tick;
`endif

    freq_divide_prog #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .pending  (pending),
        .out_clk  (out_clk)
`ifdef FREQ_DIV_TICK_EN
        ,
        .tick     (tick)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic o;
        logic p;
        logic t;
    } exp_t;

    exp_t sb[$];
    exp_t mon_x;
    int   checks = 0;
    int   fails  = 0;

    // Reference model: running flag, position within period, active ratio,
    // captured ratio and pending flag.
    bit          m_run;
    int unsigned m_p, m_n, m_sh;
    bit          m_pend, m_tick;

    function automatic void model_reset();
        m_run  = 0;
        m_p    = 0;
        m_n    = DEF;
        m_sh   = DEF;
        m_pend = 0;
        m_tick = 0;
    endfunction

    function automatic void model_step(bit e, bit ld, int unsigned v);
        int unsigned c;
        c      = (v < 2) ? 2 : v;
        m_tick = 0;
        if (!m_run) begin
            if (ld) begin
                m_n  = c;
                m_sh = c;
            end else if (m_pend) begin
                m_n = m_sh;
            end
            m_pend = 0;
            if (e) begin
                m_run  = 1;
                m_p    = 0;
                m_tick = 1;
            end
        end else begin
            if (m_p == m_n - 1) begin
                if (m_pend) m_n = m_sh;
                m_pend = 0;
                m_p    = 0;
                if (!e) m_run = 0;
                m_tick = m_run;
            end else begin
                m_p = m_p + 1;
            end
            if (ld) begin
                m_sh   = c;
                m_pend = 1;
            end
        end
    endfunction

    function automatic bit model_out();
        return m_run && (m_p < (m_n + 1) / 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step(input bit e, input bit ld, input int unsigned v);
        exp_t x;
        @(negedge clk);
        en       = e;
        div_load = ld;
        div_val  = CNT_W'(v);
        model_step(e, ld, v);
        x.o = model_out();
        x.p = m_pend;
        x.t = m_tick;
        sb.push_back(x);
    endtask

    task automatic stop_run();
        for (int i = 0; i < 40 && m_run; i++) step(0, 0, 0);
        check("stop_reached_idle", {31'd0, m_run}, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_out", out_clk, 0);
        check("rst_async_pending", pending, 0);
        en       = 1'b0;
        div_load = 1'b0;
        model_reset();
        @(posedge clk);
        #2;
        check("rst_hold_out", out_clk, 0);
        rst = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_x = sb.pop_front();
            check("out_clk", out_clk, mon_x.o);
            check("pending", pending, mon_x.p);
`ifdef FREQ_DIV_TICK_EN
            check("tick", tick, mon_x.t);
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(posedge clk);
        #2;
        check("reset_out", out_clk, 0);
        check("reset_pending", pending, 0);
        rst = 1'b1;

        // default ratio 4
        repeat (12) step(1, 0, 0);
        stop_run();

        // ratio 5 loaded while idle
        step(0, 1, 5);
        repeat (15) step(1, 0, 0);
        stop_run();

        // loads of 6 then 8 during an N=4 period
        step(0, 1, 4);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 6);
        step(1, 1, 8);
        repeat (20) step(1, 0, 0);
        stop_run();

        // clamped ratios 0 and 1
        step(0, 1, 0);
        repeat (6) step(1, 0, 0);
        step(1, 1, 1);
        repeat (10) step(1, 0, 0);
        stop_run();

        // en drop at cnt=1 of N=4
        step(0, 1, 4);
        step(1, 0, 0);
        step(1, 0, 0);
        repeat (6) step(0, 0, 0);

        // reset mid high phase discards a pending ratio
        step(1, 0, 0);
        step(1, 1, 7);
        do_reset();
        repeat (10) step(1, 0, 0);
        stop_run();

        // N=3 (tick alignment in the tick build)
        step(0, 1, 3);
        repeat (9) step(1, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            step($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9));
        end

        @(posedge clk);
        #3;
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/freq_divide_prog.md
FREQ_DIVIDE_PROG -- requirements
Module: freq_divide_prog

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the divide-ratio and period counter.
REQ-002 SHALL have parameter DEFAULT_DIV, default 4: divide ratio loaded at reset.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port en, input, 1: run enable.
REQ-006 SHALL have port div_val, input, CNT_W: requested divide ratio N.
REQ-007 SHALL have port div_load, input, 1: one-cycle strobe that captures div_val.
REQ-008 SHALL have port pending, output, 1: a captured ratio is waiting to be applied.
REQ-009 SHALL have port out_clk, output, 1: registered divided clock.

Function
REQ-010 SHALL implement states IDLE (counter held at 0, out_clk=0) and RUN (counter cycles 0..N-1).
REQ-011 SHALL move from IDLE to RUN on the first clk edge with en=1; out_clk=1 and cnt=0 on that edge.
REQ-012 SHALL, in RUN, drive out_clk=1 while cnt < ceil(N/2) and 0 otherwise: period exactly N clk cycles; high phase = low phase for even N, high one cycle longer for odd N.
REQ-013 SHALL treat any captured div_val of 0 or 1 as 2; the clamp is applied at capture.
REQ-014 SHALL, on div_load=1, capture div_val into a shadow register and set pending=1 on the next edge.
REQ-015 SHALL, in RUN, apply the shadow ratio only at wrap (cnt=N-1 -> 0) and clear pending on that edge; no truncated or stretched period is ever produced.
REQ-016 SHALL, in IDLE, apply a captured ratio on the capture edge itself; pending stays 0.
REQ-017 SHALL let a later div_load overwrite an unapplied shadow value (last load wins; pending stays 1).
REQ-018 SHALL, when div_load coincides with a wrap edge, apply the previous shadow value (if any) at that wrap and hold the new value pending until the following wrap.
REQ-019 SHALL, when en falls in RUN, complete the current period and enter IDLE at its wrap; en re-asserting before that wrap cancels the stop.
REQ-020 SHALL have no combinational path from any input to out_clk or pending.

Reset
REQ-021 SHALL, while rst=0, force state=IDLE, cnt=0, active ratio=shadow=max(DEFAULT_DIV,2), pending=0, out_clk=0.
REQ-022 SHALL, on reset mid-period, drop out_clk to 0 immediately and discard any pending ratio.
REQ-023 SHALL leave reset on the first rising clk edge after rst goes high; en sampled from that edge.

Configuration
REQ-024 SHALL, with FREQ_DIV_TICK_EN defined, add output tick (1 bit) pulsing high for exactly one cycle on every edge where cnt wraps to 0 in RUN, including the IDLE->RUN edge.
REQ-025 SHALL, without FREQ_DIV_TICK_EN, have no tick port and no tick logic; all other behaviour unchanged.

Structure
REQ-026 SHALL take state encoding (IDLE/RUN) and the MIN_DIV=2 constant from shared package freq_div_pkg.
REQ-027 SHALL place the period counter (count, wrap flag, load of new terminal value) in sub-module freq_div_cnt; FSM, shadow and handshake stay in the top.

Verification
REQ-028 SHALL cover reset then en=1 with DEFAULT_DIV=4 -> out_clk 1,1,0,0 repeating, first high on the en edge.
REQ-029 SHALL cover div_val=5 loaded in IDLE, then en=1 -> pending stays 0; out_clk high 3 cycles, low 2 cycles.
REQ-030 SHALL cover div_load of 6 at cnt=1 of an N=4 period, then 8 one cycle later -> pending=1 until wrap; current period stays 4; next period is 8; pending clears at wrap.
REQ-031 SHALL cover div_val=0 and div_val=1 loads -> period 2 (1 high, 1 low).
REQ-032 SHALL cover en dropped at cnt=1 of N=4 -> period completes, IDLE entered at wrap, out_clk held 0; rst pulled low mid-high-phase -> out_clk 0 asynchronously.
REQ-033 SHALL cover FREQ_DIV_TICK_EN build with N=3 -> tick high one cycle every 3, aligned with out_clk rising.
